// File: rtl/rsa_io_disp_seq_pkg.sv
// Shared definitions for the RSA result display sequencer: state encoding,
// downstream decoder latency and default widths.
package rsa_io_disp_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // Latency of the two-digit hex 7-segment decoder fed by seq_bin
  localparam int unsigned RSA_IO_DEC_LAT = 2;

  localparam int unsigned SEQ_IDX_W_DEF   = 2;
  localparam int unsigned SEQ_DWELL_W_DEF = 24;

endpackage

// File: rtl/rsa_io_disp_seq_if.sv
// Valid/ready word handshake from the RSA core into the display sequencer.
interface rsa_io_disp_seq_if
  import rsa_io_disp_seq_pkg::*;
#(
  parameter int unsigned IDX_W = SEQ_IDX_W_DEF
);

  localparam int unsigned NUM_BYTES = 2 ** IDX_W;
  localparam int unsigned WORD_W    = 8 * NUM_BYTES;

  logic [WORD_W-1:0] seq_word;
  logic              seq_valid;
  logic              seq_ready;

  modport master (
    output seq_word,
    output seq_valid,
    input  seq_ready
  );

  modport slave (
    input  seq_word,
    input  seq_valid,
    output seq_ready
  );

endinterface

// File: rtl/rsa_io_dly.sv
// Width x depth register delay line with asynchronous active-high clear.
module rsa_io_dly #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/rsa_io_disp_seq.sv
// Steps a multi-byte RSA result onto the hex 7-segment decoder one byte at a
// time (MSB byte first), holding each byte for a latched dwell time.
module rsa_io_disp_seq
  import rsa_io_disp_seq_pkg::*;
#(
  parameter int unsigned IDX_W   = SEQ_IDX_W_DEF,
  parameter int unsigned DWELL_W = SEQ_DWELL_W_DEF,
  parameter int unsigned DEC_LAT = RSA_IO_DEC_LAT,
  parameter int unsigned LOOP    = 0
) (
  input  logic               seq_clk,
  input  logic               seq_rst,
  rsa_io_disp_seq_if.slave   seq_in,
  input  logic [DWELL_W-1:0] seq_dwell,
  input  logic               seq_hold,
  output logic [7:0]         seq_bin,
  output logic [IDX_W-1:0]   seq_idx,
  output logic [IDX_W-1:0]   seq_idx_d,
  output logic               seq_busy,
  output logic               seq_done
);

  localparam int unsigned NUM_BYTES = 2 ** IDX_W;
  localparam int unsigned WORD_W    = 8 * NUM_BYTES;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  // Byte i of the word, counting from the MSB byte
  function automatic logic [7:0] byte_at(input logic [WORD_W-1:0] w,
                                         input logic [IDX_W-1:0]  i);
    logic [WORD_W-1:0] sh;
    sh = w << {i, 3'b000};
    return sh[WORD_W-1 -: 8];
  endfunction

  state_e              state_q, state_n;
  logic [DWELL_W-1:0]  cnt_q, cnt_n;
  logic [DWELL_W-1:0]  dwell_q, dwell_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [WORD_W-1:0]   shadow_q, shadow_n;
  logic [7:0]          bin_q, bin_n;
  logic                done_q, done_n;
  logic                expire_c, last_c, accept_c;

  // Hold freezes the dwell count and suppresses expiry
  assign expire_c = (state_q == ST_SHOW) && !seq_hold && (cnt_q == dwell_q - DWELL_ONE);
  assign last_c   = (idx_q == LAST_IDX);

  // Ready never looks at valid; in loop mode the wrap cycle doubles as an accept slot
  assign seq_in.seq_ready = (state_q == ST_IDLE) || ((LOOP != 0) && expire_c && last_c);
  assign accept_c         = seq_in.seq_valid && seq_in.seq_ready;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    shadow_n = shadow_q;
    dwell_n  = dwell_q;
    bin_n    = bin_q;
    done_n   = expire_c && last_c;
    if (accept_c) begin
      state_n  = ST_SHOW;
      cnt_n    = '0;
      idx_n    = '0;
      shadow_n = seq_in.seq_word;
      dwell_n  = (seq_dwell == '0) ? DWELL_ONE : seq_dwell;
      bin_n    = seq_in.seq_word[WORD_W-1 -: 8];
    end else if (expire_c) begin
      cnt_n = '0;
      if (!last_c) begin
        idx_n = idx_q + IDX_W'(1);
        bin_n = byte_at(shadow_q, idx_n);
      end else if (LOOP != 0) begin
        idx_n = '0;
        bin_n = byte_at(shadow_q, '0);
      end else begin
        // Last byte stays on the display while idle
        state_n = ST_IDLE;
      end
    end else if ((state_q == ST_SHOW) && !seq_hold) begin
      cnt_n = cnt_q + DWELL_ONE;
    end
  end

  always_ff @(posedge seq_clk or posedge seq_rst) begin
    if (seq_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dwell_q  <= DWELL_ONE;
      idx_q    <= '0;
      shadow_q <= '0;
      bin_q    <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      dwell_q  <= dwell_n;
      idx_q    <= idx_n;
      shadow_q <= shadow_n;
      bin_q    <= bin_n;
      done_q   <= done_n;
    end
  end

  assign seq_bin  = bin_q;
  assign seq_idx  = idx_q;
  assign seq_busy = (state_q == ST_SHOW);
  assign seq_done = done_q;

  // Index tag realigned with the decoder's segment outputs
  rsa_io_dly #(
    .W     (IDX_W),
    .DEPTH (DEC_LAT)
  ) u_idx_dly (
    .clk  (seq_clk),
    .rst  (seq_rst),
    .din  (idx_q),
    .dout (seq_idx_d)
  );

endmodule
